// File: rtl/priority_grant_decoder_if.sv
// rtl/priority_grant_decoder_if.sv - encoded request in, one-hot grant lines and status out
interface priority_grant_decoder_if;
  logic enable;
  logic in0;
  logic in1;
  logic in2;
  logic valid;
  logic a, b, c, d, e, f, g, h;
  logic busy;
  logic ack;
  logic dropped;

  modport master (
    output enable, in0, in1, in2, valid,
    input  a, b, c, d, e, f, g, h, busy, ack, dropped
  );

  modport slave (
    input  enable, in0, in1, in2, valid,
    output a, b, c, d, e, f, g, h, busy, ack, dropped
  );
endinterface

// File: rtl/priority_grant_decoder.sv
// rtl/priority_grant_decoder.sv - registered 3-to-8 grant decoder with hold time and break-before-make gap
module priority_grant_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  priority_grant_decoder_if.slave  bus
);

  // A zero hold would never raise a line; treat it as a single-cycle grant.
  localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYCLES < 1) ? CNT_W'(1) : CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       grant_q, grant_n;
  logic             busy_q, busy_n;
  logic             ack_q, ack_n;
  logic             drop_q, drop_n;
  logic [2:0]       code;

  assign code = {bus.in2, bus.in1, bus.in0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      grant_q <= grant_n;
      busy_q  <= busy_n;
      ack_q   <= ack_n;
      drop_q  <= drop_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    ack_n   = 1'b0;
    drop_n  = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid) begin
            idx_n   = code;
            cnt_n   = HOLD_LD;
            state_n = GRANT;
            ack_n   = 1'b1;
          end
        end
        GRANT: begin
          // A same-index request on the last cycle still wins over the exit to GAP.
          if (bus.valid && (code == idx_q)) begin
            cnt_n = HOLD_LD;
            ack_n = 1'b1;
          end else begin
            drop_n = bus.valid;
            if (cnt_q <= CNT_W'(1)) begin
              state_n = GAP;
            end else begin
              cnt_n = cnt_q - CNT_W'(1);
            end
          end
        end
        GAP: begin
          drop_n  = bus.valid;
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they register alongside it.
    grant_n = (state_n == GRANT) ? (8'b1 << idx_n) : 8'b0;
    busy_n  = (state_n != IDLE);
  end

  assign bus.a       = grant_q[0];
  assign bus.b       = grant_q[1];
  assign bus.c       = grant_q[2];
  assign bus.d       = grant_q[3];
  assign bus.e       = grant_q[4];
  assign bus.f       = grant_q[5];
  assign bus.g       = grant_q[6];
  assign bus.h       = grant_q[7];
  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.dropped = drop_q;

endmodule

// File: tb/tb_priority_grant_decoder.sv
// tb/tb_priority_grant_decoder.sv - directed and random checks of priority_grant_decoder against a cycle model
module tb_priority_grant_decoder;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Model: owner index (-1 = none), grant cycles still to run including the current one, gap flag.
  int   m_cur = -1;
  int   m_left = 0;
  bit   m_gap = 1'b0;
  bit   m_ack = 1'b0;
  bit   m_drop = 1'b0;

  logic [7:0] lines;
  int         run;

  priority_grant_decoder_if bus ();

  priority_grant_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_left = 0; m_gap = 1'b0; m_ack = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit v, input int code);
    m_ack = 1'b0;
    m_drop = 1'b0;
    if (!en) begin
      m_cur = -1; m_left = 0; m_gap = 1'b0;
    end else if (m_cur >= 0) begin
      if (v && code == m_cur) begin
        m_left = HOLD;
        m_ack = 1'b1;
      end else begin
        m_drop = v;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_cur = -1;
          m_gap = 1'b1;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
      m_drop = v;
    end else if (v) begin
      m_cur = code;
      m_left = HOLD;
      m_ack = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_lines;
    lines = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    exp_lines = (m_cur >= 0) ? (8'd1 << m_cur) : 8'd0;
    chk({tag, "_lines"}, 32'(lines), 32'(exp_lines));
    chk({tag, "_busy"}, 32'(bus.busy), 32'((m_cur >= 0) || m_gap));
    chk({tag, "_ack"}, 32'(bus.ack), 32'(m_ack));
    chk({tag, "_dropped"}, 32'(bus.dropped), 32'(m_drop));
    chk({tag, "_onehot"}, 32'($countones(lines) <= 1), 32'd1);
    chk({tag, "_ackdrop"}, 32'(bus.ack & bus.dropped), 32'd0);
  endtask

  task automatic step(input string tag, input bit en, input bit v, input logic [2:0] code);
    bus.enable = en;
    bus.valid  = v;
    {bus.in2, bus.in1, bus.in0} = code;
    @(posedge clk);
    model_step(en, v, int'(code));
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.valid  = 1'b0;
    {bus.in2, bus.in1, bus.in0} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant of line e.
    step("t1_req", 1, 1, 3'b100);
    step("t1_hold", 1, 0, 3'b000);
    chk("t1_e_high", 32'(bus.e), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_async_lines", 32'({bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a}), 32'd0);
    chk("t1_async_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t1_idle", 1, 0, 3'b000);

    // Single request: f high for HOLD cycles, then a one-cycle gap.
    run = 0;
    step("t2_req", 1, 1, 3'b101);
    chk("t2_ack", 32'(bus.ack), 32'd1);
    if (bus.f) run++;
    for (int i = 0; i < 6; i++) begin
      step("t2_wait", 1, 0, 3'b000);
      if (bus.f) run++;
      if (i == 3) begin
        chk("t2_gap_busy", 32'(bus.busy), 32'd1);
        chk("t2_gap_f", 32'(bus.f), 32'd0);
      end
    end
    chk("t2_f_len", 32'(run), 32'(HOLD));

    // Extension with the same code keeps c high with no break.
    run = 0;
    step("t3_req", 1, 1, 3'b010);
    if (bus.c) run++;
    step("t3_wait", 1, 0, 3'b000);
    if (bus.c) run++;
    step("t3_ext", 1, 1, 3'b010);
    chk("t3_ext_ack", 32'(bus.ack), 32'd1);
    if (bus.c) run++;
    for (int i = 0; i < 6; i++) begin
      step("t3_tail", 1, 0, 3'b000);
      if (bus.c) run++;
    end
    chk("t3_c_len", 32'(run), 32'(2 + HOLD));

    // Conflicting code during a grant is dropped; h never rises.
    run = 0;
    step("t4_req", 1, 1, 3'b000);
    step("t4_conf", 1, 1, 3'b111);
    chk("t4_dropped", 32'(bus.dropped), 32'd1);
    chk("t4_a_kept", 32'(bus.a), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step("t4_tail", 1, 0, 3'b000);
      if (bus.h) run++;
    end
    chk("t4_h_never", 32'(run), 32'd0);

    // Enable removed mid-grant, then a fresh request.
    step("t5_req", 1, 1, 3'b011);
    step("t5_c2", 1, 0, 3'b000);
    step("t5_off", 0, 1, 3'b011);
    chk("t5_off_busy", 32'(bus.busy), 32'd0);
    chk("t5_off_d", 32'(bus.d), 32'd0);
    step("t5_fresh", 1, 1, 3'b110);
    chk("t5_fresh_g", 32'(bus.g), 32'd1);
    for (int i = 0; i < 6; i++) step("t5_tail", 1, 0, 3'b000);

    // Sweep every code with an idle wait after each.
    for (int c = 0; c < 8; c++) begin
      step("t6_req", 1, 1, 3'(c));
      chk("t6_line", 32'(lines), 32'(8'd1 << c));
      for (int i = 0; i < HOLD + 2; i++) step("t6_wait", 1, 0, 3'b000);
    end

    // Random traffic, mostly enabled, checked every cycle.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
